// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg
// Shared types and constants for the two-requester ALU arbiter.
//   state_t    : control FSM states (IDLE, EXEC, RESP)
//   CMD_*      : ALU command encodings (4-bit)
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CMD_W = 4;

  localparam logic [CMD_W-1:0] CMD_ADD  = 4'b0000;
  localparam logic [CMD_W-1:0] CMD_SHL  = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_SHR  = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_MOV  = 4'b0011;
  localparam logic [CMD_W-1:0] CMD_OR   = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_XOR  = 4'b0101;
  localparam logic [CMD_W-1:0] CMD_AND  = 4'b0110;
  localparam logic [CMD_W-1:0] CMD_ADDI = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_BNE  = 4'b1000;
  localparam logic [CMD_W-1:0] CMD_BEQ  = 4'b1001;
  localparam logic [CMD_W-1:0] CMD_MOVI = 4'b1010;
  localparam logic [CMD_W-1:0] CMD_CMP  = 4'b1101;
  localparam logic [CMD_W-1:0] CMD_NOP  = 4'b1111;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
// Combinational two-way round-robin grant.
//   valid[1:0]  : request lines
//   last_grant  : index of the requester granted most recently
//   grant[1:0]  : one-hot (or zero) grant
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // A lone requester always wins; on a tie the one that did not win last time goes.
  always_comb begin
    grant    = 2'b00;
    grant[0] = valid[0] & (~valid[1] | last_grant);
    grant[1] = valid[1] & (~valid[0] | ~last_grant);
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational ALU between the execute stage (requester 0) and the
// branch unit (requester 1). One operation is in flight at a time:
// accept -> EXEC (drive ALU, capture results) -> RESP (hold until rsp_ready).
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   req_valid/req_ready[1:0]        : per-requester request handshake
//   req_cmd0/1, req_a0/b0/a1/b1     : command and operands per requester
//   req_sci[1:0]                    : shift carry-in per requester
//   alu_cmd, alu_inA, alu_inB, alu_sci : drive to the shared ALU
//   alu_rslt, alu_sco/pari/zero/equal  : ALU results, same cycle
//   rsp_valid/rsp_ready             : response handshake
//   rsp_id                          : requester owning the response
//   rsp_rslt, rsp_sco/pari/zero/equal  : captured ALU results
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [CW-1:0] req_cmd0,
  input  logic [CW-1:0] req_cmd1,
  input  logic [DW-1:0] req_a0,
  input  logic [DW-1:0] req_b0,
  input  logic [DW-1:0] req_a1,
  input  logic [DW-1:0] req_b1,
  input  logic [1:0]    req_sci,
  output logic [CW-1:0] alu_cmd,
  output logic [DW-1:0] alu_inA,
  output logic [DW-1:0] alu_inB,
  output logic          alu_sci,
  input  logic [DW-1:0] alu_rslt,
  input  logic          alu_sco,
  input  logic          alu_pari,
  input  logic          alu_zero,
  input  logic          alu_equal,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_rslt,
  output logic          rsp_sco,
  output logic          rsp_pari,
  output logic          rsp_zero,
  output logic          rsp_equal
);

  // NOP is the all-ones command at any command width.
  localparam logic [CW-1:0] NOP_CMD = {CW{1'b1}};

  state_t        state, state_next;
  logic          last_grant;
  logic [1:0]    grant;
  logic          accept;
  logic          accept_id;

  logic [CW-1:0] op_cmd;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          op_sci;
  logic          op_id;

  rr_arbiter2 u_arb (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Operand registers feed the ALU permanently so its inputs never float;
  // only the command is forced to NOP while idle.
  assign alu_inA   = op_a;
  assign alu_inB   = op_b;
  assign alu_sci   = op_sci;
  assign accept_id = grant[1];

  always_comb begin
    state_next = state;
    req_ready  = 2'b00;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    alu_cmd    = op_cmd;
    case (state)
      IDLE: begin
        alu_cmd   = NOP_CMD;
        req_ready = req_valid & grant;
        if (|(req_valid & grant)) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operands latch on accept, results latch at the end of the single EXEC cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_cmd     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_sci     <= 1'b0;
      op_id      <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_rslt   <= '0;
      rsp_sco    <= 1'b0;
      rsp_pari   <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_equal  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_cmd     <= accept_id ? req_cmd1 : req_cmd0;
        op_a       <= accept_id ? req_a1 : req_a0;
        op_b       <= accept_id ? req_b1 : req_b0;
        op_sci     <= req_sci[accept_id];
        op_id      <= accept_id;
        last_grant <= accept_id;
      end
      if (state == EXEC) begin
        rsp_id    <= op_id;
        rsp_rslt  <= alu_rslt;
        rsp_sco   <= alu_sco;
        rsp_pari  <= alu_pari;
        rsp_zero  <= alu_zero;
        rsp_equal <= alu_equal;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Self-checking bench: a bench-side ALU answers the DUT, a transaction-level
// model predicts handshakes and responses, checkOutput compares every cycle.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [CW-1:0] req_cmd0, req_cmd1;
  logic [DW-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]    req_sci;
  logic [CW-1:0] alu_cmd;
  logic [DW-1:0] alu_inA, alu_inB;
  logic          alu_sci;
  logic [DW-1:0] alu_rslt;
  logic          alu_sco, alu_pari, alu_zero, alu_equal;
  logic          rsp_valid, rsp_ready, rsp_id;
  logic [DW-1:0] rsp_rslt;
  logic          rsp_sco, rsp_pari, rsp_zero, rsp_equal;

  always #5 clk = ~clk;

  alu_arbiter #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd0(req_cmd0), .req_cmd1(req_cmd1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_sci(req_sci),
    .alu_cmd(alu_cmd), .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_sci(alu_sci),
    .alu_rslt(alu_rslt), .alu_sco(alu_sco), .alu_pari(alu_pari),
    .alu_zero(alu_zero), .alu_equal(alu_equal),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_rslt(rsp_rslt), .rsp_sco(rsp_sco), .rsp_pari(rsp_pari),
    .rsp_zero(rsp_zero), .rsp_equal(rsp_equal)
  );

  typedef struct packed {
    logic [DW-1:0] rslt;
    logic          sco;
    logic          pari;
    logic          zero;
    logic          equal;
  } alu_out_t;

  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          sci;
    logic          id;
  } op_t;

  // Stand-in for the shared ALU: plain arithmetic per command.
  function automatic alu_out_t alu_fn(input logic [CW-1:0] cmd, input logic [DW-1:0] a,
                                      input logic [DW-1:0] b, input logic sci);
    alu_out_t   r;
    logic [DW:0] wide;
    r    = '0;
    wide = '0;
    case (cmd)
      CMD_ADD, CMD_ADDI: begin wide = {1'b0, a} + {1'b0, b}; r.rslt = wide[DW-1:0]; r.sco = wide[DW]; end
      CMD_SHL: begin r.rslt = {a[DW-2:0], sci}; r.sco = a[DW-1]; end
      CMD_SHR: begin r.rslt = {sci, a[DW-1:1]}; r.sco = a[0]; end
      CMD_MOV, CMD_MOVI: r.rslt = b;
      CMD_OR:  r.rslt = a | b;
      CMD_XOR: r.rslt = a ^ b;
      CMD_AND: r.rslt = a & b;
      CMD_BNE, CMD_BEQ, CMD_CMP: begin wide = {1'b0, a} - {1'b0, b}; r.rslt = wide[DW-1:0]; r.sco = wide[DW]; end
      default: r.rslt = a;
    endcase
    r.zero  = (r.rslt == '0);
    r.pari  = ^r.rslt;
    r.equal = (a == b);
    return r;
  endfunction

  alu_out_t alu_o;
  assign alu_o     = alu_fn(alu_cmd, alu_inA, alu_inB, alu_sci);
  assign alu_rslt  = alu_o.rslt;
  assign alu_sco   = alu_o.sco;
  assign alu_pari  = alu_o.pari;
  assign alu_zero  = alu_o.zero;
  assign alu_equal = alu_o.equal;

  // Transaction model: busy from accept until the response is taken;
  // the first busy cycle is the ALU cycle, the rest present the response.
  bit  m_known = 1'b0;
  bit  m_busy, m_exec, m_last;
  op_t m_op;
  int  m_acc;
  bit  drop_on_accept = 1'b1;
  int  n_tests = 0;
  int  n_fail  = 0;

  function automatic logic [1:0] model_grant(input logic [1:0] v, input bit last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    alu_out_t e;
    if (!m_known) return;
    chk("req_ready", {6'b0, req_ready}, m_busy ? 8'h00 : {6'b0, model_grant(req_valid, m_last)});
    chk("rsp_valid", {7'b0, rsp_valid}, {7'b0, m_busy && !m_exec});
    chk("alu_cmd", {4'b0, alu_cmd}, {4'b0, m_busy ? m_op.cmd : CMD_NOP});
    chk("alu_inA", alu_inA, m_op.a);
    chk("alu_inB", alu_inB, m_op.b);
    chk("alu_sci", {7'b0, alu_sci}, {7'b0, m_op.sci});
    if (m_busy && !m_exec) begin
      e = alu_fn(m_op.cmd, m_op.a, m_op.b, m_op.sci);
      chk("rsp_id", {7'b0, rsp_id}, {7'b0, m_op.id});
      chk("rsp_rslt", rsp_rslt, e.rslt);
      chk("rsp_flags", {4'b0, rsp_sco, rsp_pari, rsp_zero, rsp_equal},
          {4'b0, e.sco, e.pari, e.zero, e.equal});
    end
  endtask

  task automatic model_update();
    logic [1:0] g;
    m_acc = -1;
    if (reset) begin
      m_known = 1'b1; m_busy = 1'b0; m_exec = 1'b0; m_last = 1'b1; m_op = '0;
    end else if (m_known) begin
      if (!m_busy) begin
        g = model_grant(req_valid, m_last);
        if (g != 2'b00) begin
          if (g[1]) m_op = '{cmd: req_cmd1, a: req_a1, b: req_b1, sci: req_sci[1], id: 1'b1};
          else      m_op = '{cmd: req_cmd0, a: req_a0, b: req_b0, sci: req_sci[0], id: 1'b0};
          m_last = g[1];
          m_busy = 1'b1;
          m_exec = 1'b1;
          m_acc  = g[1] ? 1 : 0;
        end
      end else if (m_exec) begin
        m_exec = 1'b0;
      end else if (rsp_ready) begin
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic to_negedge();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic to_next();
    @(posedge clk);
    model_update();
    #1;
    if (drop_on_accept && m_acc >= 0) req_valid[m_acc] = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] v,
                               input logic [CW-1:0] c0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                               input logic [CW-1:0] c1, input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                               input logic [1:0] sci);
    req_valid = v;
    req_cmd0 = c0; req_a0 = a0; req_b0 = b0;
    req_cmd1 = c1; req_a1 = a1; req_b1 = b1;
    req_sci = sci;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 2'b00;
    to_negedge();
    to_next();
    reset = 1'b0;
  endtask

  // Steps until a response is presented; leaves the caller at the negedge of that cycle.
  task automatic wait_rsp(output bit got);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      to_negedge();
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        return;
      end
      to_next();
    end
    n_tests++;
    n_fail++;
    $display("[TB] FAIL rsp_timeout: got no response, required rsp_valid=1 within 10 cycles");
  endtask

  initial begin
    bit got;
    reset = 1'b1;
    rsp_ready = 1'b0;
    applyStimulus(2'b00, CMD_NOP, 0, 0, CMD_NOP, 0, 0, 2'b00);
    do_reset();

    // Reset state
    to_negedge();
    chk("rst_ready", {6'b0, req_ready}, 8'h00);
    chk("rst_rsp_valid", {7'b0, rsp_valid}, 8'h00);
    chk("rst_rsp_id", {7'b0, rsp_id}, 8'h00);
    chk("rst_rsp_rslt", rsp_rslt, 8'h00);
    chk("rst_rsp_flags", {4'b0, rsp_sco, rsp_pari, rsp_zero, rsp_equal}, 8'h00);
    chk("rst_alu_cmd", {4'b0, alu_cmd}, 8'h0f);
    to_next();

    // Single request, fixed latency
    rsp_ready = 1'b1;
    applyStimulus(2'b01, CMD_ADD, 8'd1, 8'd2, CMD_NOP, 0, 0, 2'b00);
    to_negedge(); chk("t1_ready", {6'b0, req_ready}, 8'h01); to_next();
    to_negedge(); chk("t1_exec_no_rsp", {7'b0, rsp_valid}, 8'h00); to_next();
    to_negedge();
    chk("t1_rsp_valid", {7'b0, rsp_valid}, 8'h01);
    chk("t1_rsp_id", {7'b0, rsp_id}, 8'h00);
    chk("t1_rslt", rsp_rslt, 8'd3);
    chk("t1_zero", {7'b0, rsp_zero}, 8'h00);
    to_next();

    // Simultaneous requests after reset: requester 0 first
    do_reset();
    applyStimulus(2'b11, CMD_XOR, 8'd12, 8'd2, CMD_AND, 8'd12, 8'd2, 2'b00);
    wait_rsp(got);
    if (got) begin chk("t2a_id", {7'b0, rsp_id}, 8'h00); chk("t2a_rslt", rsp_rslt, 8'd14); end
    to_next();
    wait_rsp(got);
    if (got) begin
      chk("t2b_id", {7'b0, rsp_id}, 8'h01);
      chk("t2b_rslt", rsp_rslt, 8'd0);
      chk("t2b_zero", {7'b0, rsp_zero}, 8'h01);
    end
    to_next();

    // Fairness with both requesters held valid
    do_reset();
    drop_on_accept = 1'b0;
    applyStimulus(2'b11, CMD_ADD, 8'd3, 8'd4, CMD_OR, 8'd5, 8'd6, 2'b00);
    for (int k = 0; k < 6; k++) begin
      wait_rsp(got);
      if (got) chk("fair_id", {7'b0, rsp_id}, (k % 2 == 0) ? 8'h00 : 8'h01);
      to_next();
    end
    drop_on_accept = 1'b1;
    req_valid = 2'b00;

    // Backpressure: response held, no accepts while waiting
    do_reset();
    rsp_ready = 1'b0;
    applyStimulus(2'b11, CMD_ADD, 8'd5, 8'd6, CMD_OR, 8'd1, 8'd2, 2'b00);
    wait_rsp(got);
    if (got) chk("bp_first_rslt", rsp_rslt, 8'd11);
    to_next();
    for (int k = 0; k < 5; k++) begin
      to_negedge();
      chk("bp_valid", {7'b0, rsp_valid}, 8'h01);
      chk("bp_rslt", rsp_rslt, 8'd11);
      chk("bp_ready", {6'b0, req_ready}, 8'h00);
      to_next();
    end
    rsp_ready = 1'b1;
    to_negedge(); to_next();
    to_negedge(); chk("bp_next_grant", {6'b0, req_ready}, 8'h02); to_next();
    wait_rsp(got);
    if (got) begin chk("bp_second_id", {7'b0, rsp_id}, 8'h01); chk("bp_second_rslt", rsp_rslt, 8'd3); end
    to_next();

    // Branch compares from requester 1
    applyStimulus(2'b10, CMD_NOP, 0, 0, CMD_BEQ, 8'd1, 8'd1, 2'b00);
    wait_rsp(got);
    if (got) chk("beq_equal", {7'b0, rsp_equal}, 8'h01);
    to_next();
    applyStimulus(2'b10, CMD_NOP, 0, 0, CMD_BNE, 8'd1, 8'd2, 2'b00);
    wait_rsp(got);
    if (got) chk("bne_equal", {7'b0, rsp_equal}, 8'h00);
    to_next();

    // Reset while the ALU cycle is in progress
    do_reset();
    drop_on_accept = 1'b0;
    applyStimulus(2'b11, CMD_ADD, 8'd1, 8'd1, CMD_ADD, 8'd2, 8'd2, 2'b00);
    to_negedge(); chk("mid_accept", {6'b0, req_ready}, 8'h01); to_next();
    reset = 1'b1;
    to_negedge(); chk("mid_exec", {7'b0, rsp_valid}, 8'h00); to_next();
    reset = 1'b0;
    to_negedge();
    chk("mid_after_rsp", {7'b0, rsp_valid}, 8'h00);
    chk("mid_after_tie", {6'b0, req_ready}, 8'h01);
    to_next();
    drop_on_accept = 1'b1;
    do_reset();

    // Randomized traffic with backpressure, dropped requests and rare resets
    for (int c = 0; c < 3000; c++) begin
      rsp_ready = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_sci[i] = 1'($urandom_range(0, 1));
          if (i == 0) begin
            req_cmd0 = 4'($urandom_range(0, 15));
            req_a0 = 8'($urandom_range(0, 255));
            req_b0 = ($urandom_range(0, 3) == 0) ? req_a0 : 8'($urandom_range(0, 255));
          end else begin
            req_cmd1 = 4'($urandom_range(0, 15));
            req_a1 = 8'($urandom_range(0, 255));
            req_b1 = ($urandom_range(0, 3) == 0) ? req_a1 : 8'($urandom_range(0, 255));
          end
        end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      to_negedge();
      to_next();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
